// File: rtl/pulse_train_gen_if.sv
//------------------------------------------------------------------------------
// pulse_train_gen_if : control and status bundle for pulse_train_gen. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface pulse_train_gen_if #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 8,
  parameter int TALLY_W  = 16
);
  logic [CHANNELS-1:0]         start;
  logic [CHANNELS-1:0]         stop;
  logic [CHANNELS-1:0]         mode;
  logic [CHANNELS*CNT_W-1:0]   high_len;
  logic [CHANNELS*CNT_W-1:0]   low_len;
  logic [CHANNELS-1:0]         signal;
  logic [CHANNELS-1:0]         busy;
  logic [CHANNELS-1:0]         done;
  logic [CHANNELS*TALLY_W-1:0] tally;

  modport master (
    output start, stop, mode, high_len, low_len,
    input  signal, busy, done, tally
  );

  modport slave (
    input  start, stop, mode, high_len, low_len,
    output signal, busy, done, tally
  );
endinterface

`default_nettype wire

// File: rtl/pulse_train_gen.sv
//------------------------------------------------------------------------------
// pulse_train_gen : multi-channel one-shot / periodic pulse generator. Rev 1.0
// Define PULSE_TALLY_EN to add per-channel completed-pulse counters.
//------------------------------------------------------------------------------
`default_nettype none

module pulse_train_gen #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 8,
  parameter int TALLY_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  pulse_train_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  // Counters hold length-1 so a zero-length field behaves as one cycle.
  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - 1'b1;
  endfunction

  logic [CHANNELS-1:0]         w_signal;
  logic [CHANNELS-1:0]         w_busy;
  logic [CHANNELS-1:0]         w_done;
`ifdef PULSE_TALLY_EN
  logic [CHANNELS*TALLY_W-1:0] w_tally;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0]  r_high_m1, w_high_m1_nxt;
    logic [CNT_W-1:0]  r_low_m1, w_low_m1_nxt;
    logic              r_mode, w_mode_nxt;
    logic              r_done, w_done_nxt;

    always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_high_m1_nxt = r_high_m1;
      w_low_m1_nxt  = r_low_m1;
      w_mode_nxt    = r_mode;
      w_done_nxt    = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start[c] && !bus.stop[c]) begin
            w_state_nxt   = S_HIGH;
            w_mode_nxt    = bus.mode[c];
            w_high_m1_nxt = len_m1(bus.high_len[c*CNT_W +: CNT_W]);
            w_low_m1_nxt  = len_m1(bus.low_len[c*CNT_W +: CNT_W]);
            w_cnt_nxt     = len_m1(bus.high_len[c*CNT_W +: CNT_W]);
          end
        end
        S_HIGH: begin
          if (bus.stop[c]) begin
            w_state_nxt = S_IDLE;
          end else if (r_cnt == '0) begin
            w_done_nxt = 1'b1;
            if (r_mode) begin
              w_state_nxt = S_LOW;
              w_cnt_nxt   = r_low_m1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        S_LOW: begin
          if (bus.stop[c]) begin
            w_state_nxt = S_IDLE;
          end else if (r_cnt == '0) begin
            w_state_nxt = S_HIGH;
            w_cnt_nxt   = r_high_m1;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        r_state   <= S_IDLE;
        r_cnt     <= '0;
        r_high_m1 <= '0;
        r_low_m1  <= '0;
        r_mode    <= 1'b0;
        r_done    <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_cnt     <= w_cnt_nxt;
        r_high_m1 <= w_high_m1_nxt;
        r_low_m1  <= w_low_m1_nxt;
        r_mode    <= w_mode_nxt;
        r_done    <= w_done_nxt;
      end
    end

    assign w_signal[c] = (r_state == S_HIGH);
    assign w_busy[c]   = (r_state != S_IDLE);
    assign w_done[c]   = r_done;

`ifdef PULSE_TALLY_EN
    logic [TALLY_W-1:0] r_tally;

    always_ff @(posedge clock) begin
      if (reset) begin
        r_tally <= '0;
      end else if (w_done_nxt) begin
        r_tally <= r_tally + 1'b1;
      end
    end

    assign w_tally[c*TALLY_W +: TALLY_W] = r_tally;
`endif
  end

  assign bus.signal = w_signal;
  assign bus.busy   = w_busy;
  assign bus.done   = w_done;
`ifdef PULSE_TALLY_EN
  assign bus.tally  = w_tally;
`else
  assign bus.tally  = {CHANNELS*TALLY_W{1'b0}};
`endif

endmodule

`default_nettype wire
